// File: rtl/ex_stall_ctrl_pkg.sv
// Shared types and constants for the EX-stage hazard/stall controller.
// Also holds the bubble encoding the ID/EX register loads on id_ex_bubble.
package ex_stall_ctrl_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    MD_WAIT = 1'b1
  } state_t;

  localparam int REG_W = 5;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/ex_stall_ctrl_if.sv
// Pipeline-side signal bundle of ex_stall_ctrl: ID/EX and IF/ID status in, stall controls out.
// master = pipeline/bench side, slave = controller side.
interface ex_stall_ctrl_if
  import ex_stall_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
);

  logic             ID_EX_enable_out;
  logic             ID_EX_MemRead;
  logic             ID_EX_MulDiv;
  logic [REG_W-1:0] ID_EX_Rd;
  logic [REG_W-1:0] IF_ID_Rs1;
  logic [REG_W-1:0] IF_ID_Rs2;
  logic             IF_ID_UseRs1;
  logic             IF_ID_UseRs2;
  logic             mem_stall;
  logic             flush;
  logic             md_done;

  logic             combined_stall;
  logic             if_id_hold;
  logic             id_ex_bubble;
  logic             md_start;
  logic             md_abort;
  logic             md_timeout_err;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output ID_EX_enable_out, ID_EX_MemRead, ID_EX_MulDiv, ID_EX_Rd,
           IF_ID_Rs1, IF_ID_Rs2, IF_ID_UseRs1, IF_ID_UseRs2,
           mem_stall, flush, md_done,
    input  combined_stall, if_id_hold, id_ex_bubble, md_start, md_abort,
           md_timeout_err, stall_cycles
  );

  modport slave (
    input  ID_EX_enable_out, ID_EX_MemRead, ID_EX_MulDiv, ID_EX_Rd,
           IF_ID_Rs1, IF_ID_Rs2, IF_ID_UseRs1, IF_ID_UseRs2,
           mem_stall, flush, md_done,
    output combined_stall, if_id_hold, id_ex_bubble, md_start, md_abort,
           md_timeout_err, stall_cycles
  );

endinterface

// File: rtl/ex_stall_ctrl_load_use_detect.sv
// Load-use hazard compare between the load in ID/EX and the sources in IF/ID.
// Purely combinational, zero latency, no flow control.
module ex_stall_ctrl_load_use_detect
  import ex_stall_ctrl_pkg::*;
(
  input  logic             valid_i,
  input  logic             mem_read_i,
  input  logic [REG_W-1:0] rd_i,
  input  logic [REG_W-1:0] rs1_i,
  input  logic [REG_W-1:0] rs2_i,
  input  logic             use_rs1_i,
  input  logic             use_rs2_i,
  output logic             lu_hazard_o
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit     = (rd_i == rs1_i) & use_rs1_i;
  assign rs2_hit     = (rd_i == rs2_i) & use_rs2_i;
  // x0 is never a real dependency
  assign lu_hazard_o = valid_i & mem_read_i & (rd_i != '0) & (rs1_hit | rs2_hit);

endmodule

// File: rtl/ex_stall_ctrl.sv
// EX-stage stall controller: load-use bubbles, mul/div start/wait/abort sequencing, stall counter.
// All controls are Mealy (same cycle as inputs); mem_stall freezes issue and pauses the mul/div timeout.
module ex_stall_ctrl
  import ex_stall_ctrl_pkg::*;
#(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input  logic          clk,
  input  logic          reset,
  ex_stall_ctrl_if.slave io
);

  localparam int WAIT_W = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MD_TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wcnt_q, wcnt_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic lu_hazard;
  logic md_req;
  logic eff_done;
  logic stall_c, hold_c, bubble_c, start_c, abort_c;
  logic stall_o;

  ex_stall_ctrl_load_use_detect u_lu (
    .valid_i     (io.ID_EX_enable_out),
    .mem_read_i  (io.ID_EX_MemRead),
    .rd_i        (io.ID_EX_Rd),
    .rs1_i       (io.IF_ID_Rs1),
    .rs2_i       (io.IF_ID_Rs2),
    .use_rs1_i   (io.IF_ID_UseRs1),
    .use_rs2_i   (io.IF_ID_UseRs2),
    .lu_hazard_o (lu_hazard)
  );

  assign md_req   = io.ID_EX_enable_out & io.ID_EX_MulDiv;
  // a done seen under mem_stall is remembered so the unit need not hold it
  assign eff_done = io.md_done | done_q;

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    done_d   = done_q;
    err_d    = err_q;
    stall_c  = 1'b0;
    hold_c   = 1'b0;
    bubble_c = 1'b0;
    start_c  = 1'b0;
    abort_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (io.flush) begin
          bubble_c = 1'b1;
        end else if (io.mem_stall) begin
          stall_c = 1'b1;
          hold_c  = 1'b1;
        end else if (md_req) begin
          start_c = 1'b1;
          stall_c = 1'b1;
          hold_c  = 1'b1;
          state_d = MD_WAIT;
          wcnt_d  = '0;
          done_d  = 1'b0;
        end else if (lu_hazard) begin
          hold_c   = 1'b1;
          bubble_c = 1'b1;
        end
      end
      MD_WAIT: begin
        stall_c = 1'b1;
        hold_c  = 1'b1;
        if (io.flush) begin
          abort_c  = 1'b1;
          bubble_c = 1'b1;
          stall_c  = 1'b0;
          state_d  = IDLE;
          done_d   = 1'b0;
        end else if (eff_done && !io.mem_stall) begin
          stall_c = 1'b0;
          hold_c  = 1'b0;
          state_d = IDLE;
          done_d  = 1'b0;
        end else if (eff_done) begin
          done_d = 1'b1;
        end else if (!io.mem_stall) begin
          if (wcnt_q == WAIT_LAST) begin
            abort_c  = 1'b1;
            err_d    = 1'b1;
            stall_c  = 1'b0;
            bubble_c = 1'b1;
            state_d  = IDLE;
          end else begin
            wcnt_d = wcnt_q + WAIT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are forced low for the whole time reset is asserted
  assign stall_o           = stall_c & ~reset;
  assign io.combined_stall = stall_o;
  assign io.if_id_hold     = hold_c & ~reset;
  assign io.id_ex_bubble   = bubble_c & ~reset;
  assign io.md_start       = start_c & ~reset;
  assign io.md_abort       = abort_c & ~reset;
  assign io.md_timeout_err = err_q;
  assign io.stall_cycles   = stall_cnt_q;

  assign stall_cnt_d = (stall_o && (stall_cnt_q != {CNT_W{1'b1}})) ?
                       stall_cnt_q + CNT_W'(1) : stall_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      wcnt_q      <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      done_q      <= done_d;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_ex_stall_ctrl.sv
// Directed bench for ex_stall_ctrl with MD_TIMEOUT=8 and CNT_W=4.
// Output vector order in checks: {combined_stall, if_id_hold, id_ex_bubble, md_start, md_abort}.
module tb_ex_stall_ctrl;

  localparam int TO = 8;
  localparam int CW = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  ex_stall_ctrl_if #(.CNT_W(CW)) bus ();

  ex_stall_ctrl #(.MD_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic idle_in();
    bus.ID_EX_enable_out = 1'b0;
    bus.ID_EX_MemRead    = 1'b0;
    bus.ID_EX_MulDiv     = 1'b0;
    bus.ID_EX_Rd         = '0;
    bus.IF_ID_Rs1        = '0;
    bus.IF_ID_Rs2        = '0;
    bus.IF_ID_UseRs1     = 1'b0;
    bus.IF_ID_UseRs2     = 1'b0;
    bus.mem_stall        = 1'b0;
    bus.flush            = 1'b0;
    bus.md_done          = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_o(input string tag, input logic [4:0] exp);
    logic [4:0] obs;
    obs = {bus.combined_stall, bus.if_id_hold, bus.id_ex_bubble, bus.md_start, bus.md_abort};
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_v(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // settle combinational outputs, check, then advance one clock
  task automatic cyc(input string tag, input logic [4:0] exp);
    #2;
    chk_o(tag, exp);
    tick();
  endtask

  task automatic md_issue();
    bus.ID_EX_enable_out = 1'b1;
    bus.ID_EX_MulDiv     = 1'b1;
  endtask

  initial begin
    idle_in();
    // outputs held low during reset even with a mul/div request and flush present
    md_issue();
    bus.flush = 1'b1;
    #2;
    chk_o("reset_outs", 5'b00000);
    chk_v("reset_err", 32'(bus.md_timeout_err), 32'd0);
    chk_v("reset_cnt", 32'(bus.stall_cycles), 32'd0);
    tick();
    tick();
    idle_in();
    reset = 1'b0;
    cyc("idle", 5'b00000);

    // load-use on rs1
    bus.ID_EX_enable_out = 1'b1;
    bus.ID_EX_MemRead    = 1'b1;
    bus.ID_EX_Rd         = 5'd5;
    bus.IF_ID_Rs1        = 5'd5;
    bus.IF_ID_UseRs1     = 1'b1;
    cyc("lu_rs1", 5'b01100);
    bus.ID_EX_enable_out = 1'b0;
    cyc("lu_after_bubble", 5'b00000);
    // rd = x0 is not a hazard
    bus.ID_EX_enable_out = 1'b1;
    bus.ID_EX_Rd         = 5'd0;
    bus.IF_ID_Rs1        = 5'd0;
    cyc("lu_x0", 5'b00000);
    // rs2 match, then same match but rs2 unused
    bus.ID_EX_Rd     = 5'd7;
    bus.IF_ID_Rs1    = 5'd3;
    bus.IF_ID_Rs2    = 5'd7;
    bus.IF_ID_UseRs2 = 1'b1;
    cyc("lu_rs2", 5'b01100);
    bus.IF_ID_UseRs2 = 1'b0;
    cyc("lu_rs2_unused", 5'b00000);
    idle_in();
    chk_v("lu_no_stall_cnt", 32'(bus.stall_cycles), 32'd0);

    // mul/div with done on the 6th MD_WAIT cycle
    md_issue();
    cyc("md_start", 5'b11010);
    for (int i = 0; i < 5; i++) cyc("md_wait", 5'b11000);
    bus.md_done = 1'b1;
    cyc("md_done", 5'b00000);
    idle_in();
    cyc("md_back_idle", 5'b00000);
    chk_v("md_stall_cnt", 32'(bus.stall_cycles), 32'd6);

    // timeout: abort on the 8th MD_WAIT cycle
    md_issue();
    cyc("to_start", 5'b11010);
    idle_in();
    for (int i = 0; i < 7; i++) cyc("to_wait", 5'b11000);
    cyc("to_abort", 5'b01101);
    cyc("to_idle", 5'b00000);
    chk_v("to_err", 32'(bus.md_timeout_err), 32'd1);
    chk_v("to_stall_cnt", 32'(bus.stall_cycles), 32'd14);

    // flush together with done on the 3rd MD_WAIT cycle; counter saturates at 15
    md_issue();
    cyc("fl_start", 5'b11010);
    idle_in();
    cyc("fl_wait1", 5'b11000);
    cyc("fl_wait2", 5'b11000);
    bus.flush   = 1'b1;
    bus.md_done = 1'b1;
    cyc("fl_abort", 5'b01101);
    bus.flush = 1'b0;
    cyc("fl_no_capture", 5'b00000);
    idle_in();
    chk_v("fl_sat_cnt", 32'(bus.stall_cycles), 32'd15);
    chk_v("fl_err_sticky", 32'(bus.md_timeout_err), 32'd1);

    // flush overrides mem_stall and a mul/div request in IDLE
    md_issue();
    bus.mem_stall = 1'b1;
    bus.flush     = 1'b1;
    cyc("idle_flush_prio", 5'b00100);
    idle_in();

    // minimum occupancy: done on the first MD_WAIT cycle
    md_issue();
    cyc("min_start", 5'b11010);
    idle_in();
    bus.md_done = 1'b1;
    cyc("min_done", 5'b00000);
    idle_in();
    cyc("min_idle", 5'b00000);

    // asynchronous reset in the middle of MD_WAIT
    md_issue();
    cyc("rmw_start", 5'b11010);
    idle_in();
    #2;
    chk_o("rmw_wait", 5'b11000);
    reset = 1'b1;
    #1;
    chk_o("rmw_rst_outs", 5'b00000);
    chk_v("rmw_rst_cnt", 32'(bus.stall_cycles), 32'd0);
    chk_v("rmw_rst_err", 32'(bus.md_timeout_err), 32'd0);
    tick();
    #2;
    chk_o("rmw_rst_edge", 5'b00000);
    tick();
    reset = 1'b0;
    cyc("rmw_idle", 5'b00000);

    // mem_stall delays the start by 3 cycles, then a done under mem_stall is latched
    md_issue();
    bus.mem_stall = 1'b1;
    for (int i = 0; i < 3; i++) cyc("ms_hold", 5'b11000);
    bus.mem_stall = 1'b0;
    cyc("ms_start", 5'b11010);
    idle_in();
    cyc("ms_wait", 5'b11000);
    bus.mem_stall = 1'b1;
    bus.md_done   = 1'b1;
    cyc("ms_done_stalled", 5'b11000);
    bus.md_done = 1'b0;
    cyc("ms_latched_stalled", 5'b11000);
    bus.mem_stall = 1'b0;
    cyc("ms_exit", 5'b00000);
    cyc("ms_idle", 5'b00000);
    chk_v("ms_stall_cnt", 32'(bus.stall_cycles), 32'd7);

    // saturation: 10 more stall cycles from 7 holds at 15
    bus.mem_stall = 1'b1;
    for (int i = 0; i < 10; i++) cyc("sat_stall", 5'b11000);
    chk_v("sat_cnt", 32'(bus.stall_cycles), 32'd15);
    bus.mem_stall = 1'b0;
    cyc("sat_idle", 5'b00000);
    chk_v("sat_hold", 32'(bus.stall_cycles), 32'd15);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ex_stall_ctrl.md
# ex_stall_ctrl

Hazard and stall controller for the execute stage. It sits between the ID/EX pipeline register, the EX stage and a multi-cycle multiply/divide unit that shares the EX slot. It produces the `combined_stall` consumed by the EX stage, plus the IF/ID hold and ID/EX bubble controls. It also sequences multi-cycle operations: start pulse, wait for completion, timeout abort, and a saturating stall-cycle counter.

## Interface
- `MD_TIMEOUT`, default 64: maximum cycles in MD_WAIT before abort; must be ≥2.
- `CNT_W`, default 32: width of the stall-cycle counter.

- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `ID_EX_enable_out` in 1: ID/EX holds a valid instruction.
- `ID_EX_MemRead` in 1: the instruction in ID/EX is a load.
- `ID_EX_MulDiv` in 1: the instruction in ID/EX is a multi-cycle mul/div.
- `ID_EX_Rd` in 5: destination register in ID/EX.
- `IF_ID_Rs1`, `IF_ID_Rs2` in 5 each: sources of the instruction in IF/ID.
- `IF_ID_UseRs1`, `IF_ID_UseRs2` in 1 each: source actually read.
- `mem_stall` in 1: downstream memory stall.
- `flush` in 1: redirect/exception flush request.
- `md_done` in 1: mul/div result ready; valid only in MD_WAIT.
- `combined_stall` out 1: stall to the EX stage.
- `if_id_hold` out 1: freeze PC and IF/ID.
- `id_ex_bubble` out 1: load NOP into ID/EX.
- `md_start` out 1: one-cycle start pulse to mul/div.
- `md_abort` out 1: one-cycle abort pulse to mul/div.
- `md_timeout_err` out 1: sticky timeout flag.
- `stall_cycles` out CNT_W: saturating count of cycles with `combined_stall`=1.

## Operation
- FSM states: IDLE, MD_WAIT.
- `lu_hazard` = `ID_EX_enable_out` & `ID_EX_MemRead` & (`ID_EX_Rd`≠0) & ((`Rd`==`Rs1` & `UseRs1`) | (`Rd`==`Rs2` & `UseRs2`)).
- `md_req` = `ID_EX_enable_out` & `ID_EX_MulDiv`.

IDLE, evaluated in priority order:
- `flush`: `id_ex_bubble`=1, no stall, stay IDLE. Flush overrides every other condition.
- `mem_stall`: `combined_stall`=1, `if_id_hold`=1, no `md_start`, stay IDLE. The request is re-evaluated next cycle.
- `md_req`: `md_start`=1, `combined_stall`=1, `if_id_hold`=1. Go to MD_WAIT and clear the wait counter.
- `lu_hazard`: `if_id_hold`=1, `id_ex_bubble`=1, `combined_stall`=0. Stay IDLE. The hazard clears naturally on the next cycle once the bubble is in ID/EX.

MD_WAIT:
- Defaults: `combined_stall`=1, `if_id_hold`=1.
- `flush`: `md_abort`=1, `id_ex_bubble`=1, `combined_stall`=0. Go to IDLE.
- `md_done` & ~`mem_stall`: `combined_stall`=0, `if_id_hold`=0. Go to IDLE. The EX stage captures the result this cycle.
- `md_done` & `mem_stall`: stay in MD_WAIT with stall held. The done condition is latched internally, so it does not need to be held by the mul/div unit. Leave once `mem_stall` drops.
- Counter reaches `MD_TIMEOUT`-1 without done: `md_abort`=1, set `md_timeout_err`, `combined_stall`=0, `id_ex_bubble`=1. Go to IDLE.
- The counter pauses while `mem_stall`=1.

Other rules:
- `md_timeout_err` is cleared only by reset.
- `stall_cycles` increments on every cycle with `combined_stall`=1 and saturates at all-ones.
- The wait counter is ceil(log2(`MD_TIMEOUT`)) bits and never wraps.

## Timing
- All outputs are Mealy: combinational from state and inputs, with no added latency.
- `md_start` and `md_abort` are exactly one cycle wide and are never high together.
- Minimum mul/div occupancy is 2 cycles: the start cycle, plus `md_done` on the first MD_WAIT cycle.
- Reset (asynchronous, any state including mid-MD_WAIT): state=IDLE, counters=0, `md_timeout_err`=0. All outputs 0 while reset is asserted. No abort pulse is generated.
- Simultaneous `md_done` and `flush` in MD_WAIT: flush wins, so `md_abort`=1 and the result is discarded.
- Simultaneous `md_done` and timeout: done wins.

## Structure
- Shared package:
  - FSM state enum (IDLE, MD_WAIT).
  - Register-index width constant (5).
  - NOP/bubble encoding constant, also used by the ID/EX register.
- Optional sub-module `load_use_detect`: the combinational `lu_hazard` compare.
- All remaining logic stays in one module.

## Test plan
- Load `x5` in ID/EX, IF/ID reads `rs1=x5` → one cycle of `if_id_hold`=1 and `id_ex_bubble`=1, `combined_stall`=0, then all outputs 0. Repeat with `Rd=x0` → no hazard.
- Mul/div request, `md_done` after 5 MD_WAIT cycles → `md_start` for 1 cycle, `combined_stall` high for 6 cycles, `stall_cycles`=6.
- Mul/div with `md_done` never asserted, `MD_TIMEOUT`=8 → `md_abort` on cycle 8, `md_timeout_err`=1 held until reset.
- `flush` on the 3rd MD_WAIT cycle with `md_done` in the same cycle → `md_abort`=1, FSM in IDLE, no result-capture cycle.
- `mem_stall` for 3 cycles over a mul/div request, then `md_done` during a further `mem_stall` → `md_start` delayed 3 cycles, exit from MD_WAIT delayed until `mem_stall` drops.
- Reset asserted mid-MD_WAIT, then `CNT_W`=4 saturation run → outputs all 0 at the reset edge with no abort pulse; later `stall_cycles` holds at 15.
